mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE,
// with an EXCEPT state for illegal instructions and memory timeouts.
// Outputs are decoded from the state and the latched instruction register.
// The only inputs they depend on are zero (beq, in EXEC) and mem_ready (sw, in MEM).
module mips_multicycle_ctrl #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 8,
  parameter int RETIRE_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                instr_valid,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  input  logic                zero,
  input  logic                exc_clear,
  output logic                instr_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src2,
  output logic                rd_src,
  output logic                writeenable,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_we,
  output logic                branch_taken,
  output logic                except,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXCEPT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  // Counter only needs to reach MEM_TIMEOUT-1; a zero timeout keeps a 1-bit stub.
  localparam int              CNT_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t               state_r;
  logic [5:0]           ir_op_r;
  logic [5:0]           ir_fn_r;
  logic [CNT_W-1:0]     mem_cnt_r;
  logic [RETIRE_W-1:0]  retired_r;

  logic                 is_rtype_s;
  logic                 is_ialu_s;
  logic                 is_lw_s;
  logic                 is_sw_s;
  logic                 is_beq_s;
  logic                 legal_s;
  logic [2:0]           alu_code_s;
  logic                 mem_timeout_s;

  assign retired = retired_r;

  // Instruction class and ALU code decoded from the latched IR.
  always_comb begin
    is_rtype_s = 1'b0;
    is_ialu_s  = 1'b0;
    is_lw_s    = 1'b0;
    is_sw_s    = 1'b0;
    is_beq_s   = 1'b0;
    alu_code_s = 3'd0;
    case (ir_op_r)
      OP_RTYPE: begin
        case (ir_fn_r)
          FN_ADD:  begin is_rtype_s = 1'b1; alu_code_s = 3'd2; end
          FN_SUB:  begin is_rtype_s = 1'b1; alu_code_s = 3'd3; end
          FN_AND:  begin is_rtype_s = 1'b1; alu_code_s = 3'd4; end
          FN_OR:   begin is_rtype_s = 1'b1; alu_code_s = 3'd5; end
          FN_NOR:  begin is_rtype_s = 1'b1; alu_code_s = 3'd6; end
          FN_XOR:  begin is_rtype_s = 1'b1; alu_code_s = 3'd7; end
          default: begin is_rtype_s = 1'b0; alu_code_s = 3'd0; end
        endcase
      end
      OP_ADDI: begin is_ialu_s = 1'b1; alu_code_s = 3'd2; end
      OP_ANDI: begin is_ialu_s = 1'b1; alu_code_s = 3'd4; end
      OP_ORI:  begin is_ialu_s = 1'b1; alu_code_s = 3'd5; end
      OP_XORI: begin is_ialu_s = 1'b1; alu_code_s = 3'd7; end
      OP_LW:   begin is_lw_s   = 1'b1; alu_code_s = 3'd2; end
      OP_SW:   begin is_sw_s   = 1'b1; alu_code_s = 3'd2; end
      OP_BEQ:  begin is_beq_s  = 1'b1; alu_code_s = 3'd3; end
      default: begin alu_code_s = 3'd0; end
    endcase
    legal_s       = is_rtype_s | is_ialu_s | is_lw_s | is_sw_s | is_beq_s;
    mem_timeout_s = TIMEOUT_EN && (mem_cnt_r == CNT_LAST);
  end

  // Control outputs per state; alu_op and operand selects only in EXEC/MEM/WB.
  always_comb begin
    instr_ready  = 1'b0;
    alu_op       = {ALU_OP_W{1'b0}};
    alu_src2     = 1'b0;
    rd_src       = 1'b0;
    writeenable  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    pc_we        = 1'b0;
    branch_taken = 1'b0;
    except       = 1'b0;
    case (state_r)
      S_IDLE: begin
        instr_ready = 1'b1;
      end
      S_DECODE: begin
        instr_ready = 1'b0;
      end
      S_EXEC: begin
        alu_op   = ALU_OP_W'(alu_code_s);
        alu_src2 = is_ialu_s | is_lw_s | is_sw_s;
        rd_src   = is_ialu_s | is_lw_s;
        if (is_beq_s) begin
          pc_we        = 1'b1;
          branch_taken = zero;
        end else begin
          pc_we        = 1'b0;
          branch_taken = 1'b0;
        end
      end
      S_MEM: begin
        alu_op    = ALU_OP_W'(alu_code_s);
        alu_src2  = 1'b1;
        rd_src    = is_lw_s;
        mem_read  = is_lw_s;
        mem_write = is_sw_s;
        if (is_sw_s && mem_ready) begin
          pc_we = 1'b1;
        end else begin
          pc_we = 1'b0;
        end
      end
      S_WB: begin
        alu_op      = ALU_OP_W'(alu_code_s);
        alu_src2    = is_ialu_s | is_lw_s;
        rd_src      = is_ialu_s | is_lw_s;
        writeenable = 1'b1;
        pc_we       = 1'b1;
      end
      S_EXCEPT: begin
        except = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  // State sequencing, IR capture, memory wait counter and retirement count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      ir_op_r   <= 6'd0;
      ir_fn_r   <= 6'd0;
      mem_cnt_r <= {CNT_W{1'b0}};
      retired_r <= {RETIRE_W{1'b0}};
    end else begin
      if (pc_we) begin
        retired_r <= retired_r + RETIRE_W'(1);
      end
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            ir_op_r <= opcode;
            ir_fn_r <= funct;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_r <= legal_s ? S_EXEC : S_EXCEPT;
        end
        S_EXEC: begin
          mem_cnt_r <= {CNT_W{1'b0}};
          if (is_beq_s) begin
            state_r <= S_IDLE;
          end else if (is_lw_s || is_sw_s) begin
            state_r <= S_MEM;
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          // A ready on the last allowed cycle still completes the access.
          if (mem_ready) begin
            mem_cnt_r <= {CNT_W{1'b0}};
            state_r   <= is_lw_s ? S_WB : S_IDLE;
          end else if (mem_timeout_s) begin
            state_r <= S_EXCEPT;
          end else begin
            mem_cnt_r <= mem_cnt_r + CNT_W'(1);
          end
        end
        S_WB: begin
          state_r <= S_IDLE;
        end
        S_EXCEPT: begin
          if (exc_clear) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each scenario queues per-cycle
// stimulus together with the expected outputs, then replays the queue.
module tb_mips_multicycle_ctrl;

  localparam int RW = 2;

  logic          clock;
  logic          reset_n;
  logic          instr_valid;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          mem_ready;
  logic          zero;
  logic          exc_clear;
  logic          instr_ready;
  logic [2:0]    alu_op;
  logic          alu_src2;
  logic          rd_src;
  logic          writeenable;
  logic          mem_read;
  logic          mem_write;
  logic          pc_we;
  logic          branch_taken;
  logic          except;
  logic [RW-1:0] retired;

  mips_multicycle_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(8), .RETIRE_W(RW)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid),
    .opcode(opcode), .funct(funct), .mem_ready(mem_ready), .zero(zero),
    .exc_clear(exc_clear), .instr_ready(instr_ready), .alu_op(alu_op),
    .alu_src2(alu_src2), .rd_src(rd_src), .writeenable(writeenable),
    .mem_read(mem_read), .mem_write(mem_write), .pc_we(pc_we),
    .branch_taken(branch_taken), .except(except), .retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {instr_ready, alu_op[2:0], alu_src2, rd_src, writeenable, mem_read, mem_write, pc_we, branch_taken, except}
  logic [11:0] obs;
  assign obs = {instr_ready, alu_op, alu_src2, rd_src, writeenable,
                mem_read, mem_write, pc_we, branch_taken, except};

  localparam logic [11:0] IDLE_O = 12'b1000_0000_0000;
  localparam logic [11:0] NONE_O = 12'b0000_0000_0000;
  localparam logic [11:0] EXC_O  = 12'b0000_0000_0001;
  // Garbage driven on opcode/funct outside the handshake cycle.
  localparam logic [5:0]  JOP    = 6'h2B;
  localparam logic [5:0]  JFN    = 6'h22;

  typedef struct {
    string        name;
    logic         v;
    logic [5:0]   op;
    logic [5:0]   fn;
    logic         mr;
    logic         z;
    logic         ec;
    logic [11:0]  out;
    logic [RW-1:0] ret;
  } step_t;

  step_t         sq[$];
  logic [RW-1:0] model_ret;
  int            checks;
  int            errors;

  function automatic logic [11:0] ov(logic ir, logic [2:0] aop, logic s2, logic rd,
                                     logic we, logic mr, logic mw, logic pw,
                                     logic bt, logic ex);
    return {ir, aop, s2, rd, we, mr, mw, pw, bt, ex};
  endfunction

  function automatic void push(string nm, logic v, logic [5:0] op, logic [5:0] fn,
                               logic mr, logic z, logic ec, logic [11:0] out);
    step_t e;
    e.name = nm; e.v = v; e.op = op; e.fn = fn;
    e.mr = mr; e.z = z; e.ec = ec; e.out = out; e.ret = model_ret;
    sq.push_back(e);
    if (out[2]) model_ret = model_ret + 2'd1;
  endfunction

  // Full ALU-class instruction: IDLE handshake, DECODE, EXEC, WB.
  function automatic void push_alu(string nm, logic [5:0] op, logic [5:0] fn,
                                   logic [2:0] aop, logic s2, logic rd);
    push({nm, "_idle"}, 1'b1, op, fn, 1'b0, 1'b0, 1'b0, IDLE_O);
    push({nm, "_dec"},  1'b0, JOP, JFN, 1'b1, 1'b1, 1'b0, NONE_O);
    push({nm, "_exec"}, 1'b0, JOP, JFN, 1'b1, 1'b1, 1'b0,
         ov(1'b0, aop, s2, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push({nm, "_wb"},   1'b0, JOP, JFN, 1'b0, 1'b1, 1'b0,
         ov(1'b0, aop, s2, rd, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; instr_valid = 1'b1; opcode = 6'h00; funct = 6'h20;
    mem_ready = 1'b0; zero = 1'b0; exc_clear = 1'b0;
    model_ret = 2'd0;
    #2;
    checks++;
    if (obs !== IDLE_O) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", obs, IDLE_O);
    end
    checks++;
    if (retired !== 2'd0) begin
      errors++; $display("FAIL reset_retired got %0d exp 0", retired);
    end
    @(negedge clock);
    reset_n = 1'b1; instr_valid = 1'b0;
  endtask

  task automatic test_add();
    step_t st;
    push_alu("add", 6'h00, 6'h20, 3'd2, 1'b0, 1'b0);
    push("add_after", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, IDLE_O);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t st;
    logic [5:0] fns  [6] = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h20};
    logic [2:0] raop [6] = '{3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd2};
    logic [5:0] ops  [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
    logic [2:0] iaop [4] = '{3'd2, 3'd4, 3'd5, 3'd7};
    for (int i = 0; i < 6; i++) push_alu($sformatf("rtype%0d", i), 6'h00, fns[i], raop[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push_alu($sformatf("itype%0d", i), ops[i], 6'h3F, iaop[i], 1'b1, 1'b1);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_lw();
    step_t st;
    logic [11:0] mem_o;
    logic [11:0] ex_o;
    ex_o  = ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_o = ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // ready on the third MEM cycle
    push("lw_idle", 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("lw_dec",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("lw_exec", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, ex_o);
    push("lw_mem1", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, mem_o);
    push("lw_mem2", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, mem_o);
    push("lw_mem3", 1'b0, JOP, JFN, 1'b1, 1'b0, 1'b0, mem_o);
    push("lw_wb",   1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    // ready on the last allowed cycle wins over the timeout
    push("lwp_idle", 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("lwp_dec",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("lwp_exec", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, ex_o);
    for (int i = 1; i <= 8; i++)
      push($sformatf("lwp_mem%0d", i), 1'b0, JOP, JFN, (i == 8), 1'b0, 1'b0, mem_o);
    push("lwp_wb",   1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_sw();
    step_t st;
    logic [11:0] mem_o;
    logic [11:0] ex_o;
    ex_o  = ov(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_o = ov(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // completing store retires in its MEM cycle
    push("sw_idle", 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("sw_dec",  1'b0, 6'h23, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("sw_exec", 1'b0, 6'h23, JFN, 1'b0, 1'b0, 1'b0, ex_o);
    push("sw_mem1", 1'b0, 6'h23, JFN, 1'b1, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    // store that never completes times out after 8 MEM cycles
    push("swt_idle", 1'b1, 6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("swt_dec",  1'b0, 6'h23, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("swt_exec", 1'b0, 6'h23, JFN, 1'b0, 1'b0, 1'b0, ex_o);
    for (int i = 1; i <= 8; i++)
      push($sformatf("swt_mem%0d", i), 1'b0, 6'h23, JFN, 1'b0, 1'b0, 1'b0, mem_o);
    push("swt_exc1", 1'b0, JOP, JFN, 1'b1, 1'b0, 1'b0, EXC_O);
    push("swt_exc2", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, EXC_O);
    push("swt_exc3", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b1, EXC_O);
    push("swt_idle2", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, IDLE_O);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_beq();
    step_t st;
    for (int k = 0; k < 2; k++) begin
      push($sformatf("beq%0d_idle", k), 1'b1, 6'h04, 6'h00, 1'b0, 1'b1, 1'b0, IDLE_O);
      push($sformatf("beq%0d_dec", k),  1'b0, JOP, JFN, 1'b0, 1'b1, 1'b0, NONE_O);
      push($sformatf("beq%0d_exec", k), 1'b0, JOP, JFN, 1'b0, (k == 0), 1'b0,
           ov(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (k == 0), 1'b0));
    end
    push("beq_after", 1'b0, JOP, JFN, 1'b0, 1'b1, 1'b0, IDLE_O);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_illegal();
    step_t st;
    push("ill_idle", 1'b1, 6'h3F, 6'h20, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("ill_dec",  1'b0, 6'h08, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("ill_exc1", 1'b0, 6'h08, JFN, 1'b0, 1'b0, 1'b0, EXC_O);
    push("ill_exc2", 1'b0, 6'h08, JFN, 1'b0, 1'b0, 1'b1, EXC_O);
    push_alu("ill_addi", 6'h08, 6'h00, 3'd2, 1'b1, 1'b1);
    // R-type with an unsupported funct (addu)
    push("fn_idle", 1'b1, 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("fn_dec",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("fn_exc",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b1, EXC_O);
    push("fn_idle2", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, IDLE_O);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t st;
    push("rm_idle", 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, IDLE_O);
    push("rm_dec",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("rm_exec", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push("rm_mem1", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
    // asynchronous reset in the middle of the MEM wait, with ready offered
    #1 reset_n = 1'b0; mem_ready = 1'b1; instr_valid = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_O) begin
      errors++; $display("FAIL midmem_reset_outputs got %b exp %b", obs, IDLE_O);
    end
    checks++;
    if (retired !== 2'd0) begin
      errors++; $display("FAIL midmem_reset_retired got %0d exp 0", retired);
    end
    @(negedge clock);
    checks++;
    if (obs !== IDLE_O) begin
      errors++; $display("FAIL held_reset_outputs got %b exp %b", obs, IDLE_O);
    end
    // release with a handshake already offered: first rising edge takes it
    model_ret = 2'd0;
    reset_n = 1'b1; instr_valid = 1'b1; opcode = 6'h08; funct = 6'h00; mem_ready = 1'b0;
    push("wrap0_dec",  1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, NONE_O);
    push("wrap0_exec", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    push("wrap0_wb",   1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0,
         ov(1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i < 4; i++) push_alu($sformatf("wrap%0d", i), 6'h08, 6'h00, 3'd2, 1'b1, 1'b1);
    push("wrap_end", 1'b0, JOP, JFN, 1'b0, 1'b0, 1'b0, IDLE_O);
    while (sq.size() > 0) begin
      st = sq.pop_front();
      @(negedge clock);
      instr_valid = st.v; opcode = st.op; funct = st.fn;
      mem_ready = st.mr; zero = st.z; exc_clear = st.ec;
      #1;
      checks++;
      if (obs !== st.out) begin
        errors++; $display("FAIL %s outputs got %b exp %b", st.name, obs, st.out);
      end
      checks++;
      if (retired !== st.ret) begin
        errors++; $display("FAIL %s retired got %0d exp %0d", st.name, retired, st.ret);
      end
    end
    checks++;
    if (retired !== 2'd0) begin
      errors++; $display("FAIL wrap_final got %0d exp 0", retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
